pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 124 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between execute and memory stages; input-to-output latency 1 cycle.
// in_ready is registered and drops only when both entries are held, so out_ready never reaches it combinationally.
module pipe_skid_reg #(
    parameter int                DATA_W      = 32,
    parameter int                REG_AW      = 5,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result_i,
    input  logic [REG_AW-1:0] write_reg_addr_i,
    input  logic [CTRL_W-1:0] control_signal_i,
    input  logic [DATA_W-1:0] mem_write_data_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_o,
    output logic [REG_AW-1:0] write_reg_addr_o,
    output logic [CTRL_W-1:0] control_signal_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] addr;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] wdata;
    } pld_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t     r_state;
    pld_t       r_main;
    pld_t       r_skid;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [1:0] r_occ;

    pld_t w_in;
    pld_t w_bubble;
    logic w_acc;
    logic w_iss;

    assign w_in     = '{result: result_i, addr: write_reg_addr_i,
                        ctrl: control_signal_i, wdata: mem_write_data_i};
    assign w_bubble = '{result: '0, addr: '0, ctrl: CTRL_BUBBLE, wdata: '0};
    assign w_acc    = in_valid & r_in_ready;
    assign w_iss    = r_out_valid & out_ready;

    // The main entry is scrubbed to the bubble whenever it empties, so outputs need no masking.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= ST_EMPTY;
            r_main      <= w_bubble;
            r_skid      <= w_bubble;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main      <= w_in;
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_occ       <= 2'd1;
                    end
                end
                ST_FULL: begin
                    case ({w_acc, w_iss})
                        2'b11: r_main <= w_in;
                        2'b10: begin
                            r_skid     <= w_in;
                            r_state    <= ST_SKID;
                            r_in_ready <= 1'b0;
                            r_occ      <= 2'd2;
                        end
                        2'b01: begin
                            r_main      <= w_bubble;
                            r_state     <= ST_EMPTY;
                            r_out_valid <= 1'b0;
                            r_occ       <= 2'd0;
                        end
                        default: ;
                    endcase
                end
                ST_SKID: begin
                    if (w_iss) begin
                        r_main     <= r_skid;
                        r_skid     <= w_bubble;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b1;
                        r_occ      <= 2'd1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_main      <= w_bubble;
                    r_skid      <= w_bubble;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_occ       <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready         = r_in_ready;
    assign out_valid        = r_out_valid;
    assign occupancy        = r_occ;
    assign result_o         = r_main.result;
    assign write_reg_addr_o = r_main.addr;
    assign control_signal_o = r_main.ctrl;
    assign mem_write_data_o = r_main.wdata;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus a long random run against a queue-based reference.
module tb_pipe_skid_reg;

    localparam logic [15:0] BUB = 16'h8001;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  addr;
        logic [15:0] ctrl;
        logic [31:0] wd;
    } pld_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] result_i, mem_write_data_i, result_o, mem_write_data_o;
    logic [4:0]  write_reg_addr_i, write_reg_addr_o;
    logic [15:0] control_signal_i, control_signal_o;
    logic [1:0]  occupancy;

    int vectors    = 0;
    int miscompares = 0;

    pld_t mq[$];

    pipe_skid_reg #(.DATA_W(32), .REG_AW(5), .CTRL_W(16), .CTRL_BUBBLE(BUB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .result_i(result_i), .write_reg_addr_i(write_reg_addr_i),
        .control_signal_i(control_signal_i), .mem_write_data_i(mem_write_data_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_o(result_o), .write_reg_addr_o(write_reg_addr_o),
        .control_signal_o(control_signal_o), .mem_write_data_o(mem_write_data_o),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic pld_t rnd_pld();
        pld_t p;
        p.res  = $urandom;
        p.addr = 5'($urandom);
        p.ctrl = 16'($urandom);
        p.wd   = $urandom;
        return p;
    endfunction

    function automatic pld_t mk(input logic [31:0] r);
        pld_t p;
        p.res  = r;
        p.addr = r[4:0];
        p.ctrl = r[15:0] ^ 16'h5A5A;
        p.wd   = ~r;
        return p;
    endfunction

    // Drives one cycle from a negedge, updates the queue model at the posedge, returns at the next negedge.
    task automatic step(input logic rs, input logic fl, input logic iv, input logic ordy, input pld_t d);
        bit acc, iss;
        rst = rs; flush = fl; in_valid = iv; out_ready = ordy;
        result_i = d.res; write_reg_addr_i = d.addr;
        control_signal_i = d.ctrl; mem_write_data_i = d.wd;
        acc = iv && (mq.size() < 2);
        iss = ordy && (mq.size() > 0);
        @(posedge clk);
        if (rs || fl) mq.delete();
        else begin
            if (iss) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h0));
        step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'h77));
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++;
        if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        vectors++;
        if (control_signal_o !== BUB || result_o !== 32'h0 || write_reg_addr_o !== 5'h0 || mem_write_data_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_payload got ctrl=%h res=%h addr=%h wd=%h want ctrl=%h rest 0",
                     control_signal_o, result_o, write_reg_addr_o, mem_write_data_o, BUB);
        end
    endtask

    task automatic test_pass_through();
        step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h11111111));
        vectors++;
        if (result_o !== 32'h11111111 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL pass_first got %h v=%b want 11111111 v=1", result_o, out_valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h22222222));
        vectors++;
        if (result_o !== 32'h22222222) begin miscompares++; $display("FAIL pass_second got %h want 22222222", result_o); end
        vectors++;
        if (occupancy !== 2'd1) begin miscompares++; $display("FAIL pass_occ got %0d want 1", occupancy); end
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0));
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            miscompares++; $display("FAIL pass_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'hA));
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'hB));
        vectors++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_full got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'hD));
        vectors++;
        if (result_o !== 32'hA || mem_write_data_o !== ~32'hA || control_signal_o !== (16'hA ^ 16'h5A5A)) begin
            miscompares++; $display("FAIL bp_stall_hold got res=%h wd=%h want res=a", result_o, mem_write_data_o);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0));
        vectors++;
        if (result_o !== 32'hB || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            miscompares++; $display("FAIL bp_first_issue got res=%h rdy=%b occ=%0d want b 1 1", result_o, in_ready, occupancy);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0));
        vectors++;
        if (out_valid !== 1'b0 || result_o !== 32'h0) begin
            miscompares++; $display("FAIL bp_drained got v=%b res=%h want 0 0", out_valid, result_o);
        end
    endtask

    task automatic test_flush_skid();
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h1));
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h2));
        step(1'b0, 1'b1, 1'b1, 1'b1, mk(32'hC));
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || control_signal_o !== BUB) begin
            miscompares++;
            $display("FAIL flush_state got v=%b occ=%0d rdy=%b ctrl=%h want 0 0 1 %h",
                     out_valid, occupancy, in_ready, control_signal_o, BUB);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0));
            vectors++;
            if (out_valid !== 1'b0 || result_o === 32'hC) begin
                miscompares++; $display("FAIL flush_no_c got v=%b res=%h want v=0", out_valid, result_o);
            end
        end
    endtask

    task automatic test_rst_flush();
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h3));
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h4));
        step(1'b1, 1'b1, 1'b1, 1'b1, mk(32'h5));
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || control_signal_o !== BUB ||
            result_o !== 32'h0 || write_reg_addr_o !== 5'h0 || mem_write_data_o !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_flush got v=%b occ=%0d rdy=%b ctrl=%h res=%h want reset values",
                     out_valid, occupancy, in_ready, control_signal_o, result_o);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h66));
        vectors++;
        if (out_valid !== 1'b1 || result_o !== 32'h66) begin
            miscompares++; $display("FAIL post_rst_accept got v=%b res=%h want 1 66", out_valid, result_o);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0));
    endtask

    task automatic test_random();
        pld_t exp_p;
        logic exp_v, exp_r;
        for (int c = 0; c < 10000; c++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rnd_pld());
            exp_v = (mq.size() > 0);
            exp_r = (mq.size() < 2);
            if (exp_v) exp_p = mq[0];
            else exp_p = '{res: 32'h0, addr: 5'h0, ctrl: BUB, wd: 32'h0};
            vectors++;
            if (out_valid !== exp_v || in_ready !== exp_r || occupancy !== 2'(mq.size())) begin
                miscompares++;
                $display("FAIL rand_ctrl cyc %0d got v=%b rdy=%b occ=%0d want v=%b rdy=%b occ=%0d",
                         c, out_valid, in_ready, occupancy, exp_v, exp_r, mq.size());
            end
            vectors++;
            if ({result_o, write_reg_addr_o, control_signal_o, mem_write_data_o} !== exp_p) begin
                miscompares++;
                $display("FAIL rand_payload cyc %0d got %h/%h/%h/%h want %h/%h/%h/%h", c,
                         result_o, write_reg_addr_o, control_signal_o, mem_write_data_o,
                         exp_p.res, exp_p.addr, exp_p.ctrl, exp_p.wd);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        result_i = '0; write_reg_addr_i = '0; control_signal_i = '0; mem_write_data_i = '0;
        @(negedge clk);
        test_reset();
        test_pass_through();
        test_backpressure();
        test_flush_skid();
        test_rst_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
